// File: rtl/mem_responder_if.sv
// SLC-3 style asynchronous-SRAM memory port between a CPU (master) and the responder (slave).
// Handshake: the master holds CE low with one of OE/WE low; the slave pulses Ready once the access completes, and the master must release CE before the next access.
interface mem_responder_if;
   logic [15:0] ADDR;
   logic        CE;
   logic        OE;
   logic        WE;
   logic        UB;
   logic        LB;
   logic [15:0] Data_from_CPU;
   logic [15:0] Data_to_CPU;
   logic        Ready;
   logic        Err;

   modport master (
      output ADDR, CE, OE, WE, UB, LB, Data_from_CPU,
      input  Data_to_CPU, Ready, Err
   );

   modport slave (
      input  ADDR, CE, OE, WE, UB, LB, Data_from_CPU,
      output Data_to_CPU, Ready, Err
   );
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory model behind the SLC-3 memory port.
// Byte-lane masking, abort on CE release, and error strobes are supported.
module mem_responder #(
   parameter int WAIT_STATES = 2,
   parameter int DEPTH_BITS  = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   mem_responder_if.slave   bus,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_is_write;
   logic        r_ub;
   logic        r_lb;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_data;
   logic        r_err;
   logic [15:0] r_mem [2**DEPTH_BITS];

   logic        w_req;
   logic        w_illegal;
   logic        w_enter;
   logic        w_is_write;
   logic        w_ub;
   logic        w_lb;
   logic        w_oor;
   logic [15:0] w_addr;
   logic [15:0] w_word;
   logic [15:0] w_rd;

   // In IDLE the live bus is what gets captured; afterwards only the captured copy matters.
   always_comb begin
      w_req      = !bus.CE && (bus.OE ^ bus.WE);
      w_illegal  = !bus.CE && !bus.OE && !bus.WE;
      w_is_write = (r_state == S_IDLE) ? !bus.WE : r_is_write;
      w_addr     = (r_state == S_IDLE) ? bus.ADDR : r_addr;
      w_ub       = (r_state == S_IDLE) ? bus.UB : r_ub;
      w_lb       = (r_state == S_IDLE) ? bus.LB : r_lb;
      w_oor      = (w_addr >> DEPTH_BITS) != 16'd0;
      w_word     = r_mem[w_addr[DEPTH_BITS-1:0]];
      w_rd       = w_oor ? 16'h0000 : {(w_ub ? 8'h00 : w_word[15:8]), (w_lb ? 8'h00 : w_word[7:0])};
      w_enter    = ((r_state == S_IDLE) && !w_illegal && w_req && (WAIT_STATES == 0)) ||
                   ((r_state == S_WAIT) && !bus.CE && (r_cnt == 4'd0));
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_is_write <= 1'b0;
         r_ub       <= 1'b1;
         r_lb       <= 1'b1;
         r_addr     <= 16'h0000;
         r_wdata    <= 16'h0000;
         r_data     <= 16'h0000;
         r_err      <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_illegal) begin
                  r_err   <= 1'b1;
                  r_state <= S_HOLD;
               end else if (w_req) begin
                  r_is_write <= !bus.WE;
                  r_addr     <= bus.ADDR;
                  r_ub       <= bus.UB;
                  r_lb       <= bus.LB;
                  r_wdata    <= bus.Data_from_CPU;
                  if (WAIT_STATES == 0) begin
                     r_state <= S_ACCESS;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= WS_LOAD;
                  end
               end
            end
            S_WAIT: begin
               if (bus.CE) begin
                  r_state <= S_IDLE;
                  r_cnt   <= 4'd0;
               end else if (r_cnt == 4'd0) begin
                  r_state <= S_ACCESS;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_ACCESS: r_state <= S_HOLD;
            S_HOLD: begin
               if (bus.CE) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         // Read data and the out-of-range strobe both land on the edge entering ACCESS.
         if (w_enter) begin
            r_err <= w_oor;
            if (!w_is_write) r_data <= w_rd;
         end
      end
   end

   // Storage is deliberately not reset; a write only commits on the edge leaving ACCESS.
   always_ff @(posedge Clk) begin
      if ((r_state == S_ACCESS) && r_is_write && !w_oor) begin
         if (!r_lb) r_mem[r_addr[DEPTH_BITS-1:0]][7:0]  <= r_wdata[7:0];
         if (!r_ub) r_mem[r_addr[DEPTH_BITS-1:0]][15:8] <= r_wdata[15:8];
      end
   end

   assign bus.Data_to_CPU = r_data;
   assign bus.Ready       = (r_state == S_ACCESS);
   assign bus.Err         = r_err;
   assign o_dbg_state     = r_state;

endmodule
